// File: rtl/blink_pattern_seq.sv
// Plays a loaded bit pattern onto led_out, one bit per upstream tick, repeating
// it pat_reps+1 times, then pulses done. Patterns are loaded via valid/ready.
module blink_pattern_seq #(
  parameter int PBITS = 16,
  parameter int RBITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             stop,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [PBITS-1:0] pat_data,
  input  logic [RBITS-1:0] pat_reps,
  output logic             led_out,
  output logic             busy,
  output logic             done
);

  localparam int IW = $clog2(PBITS);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  state_t           state_q, state_d;
  logic [PBITS-1:0] pat_q, pat_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [RBITS-1:0] rep_q, rep_d;
  logic             led_d, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      led_out <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      led_out <= led_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    led_d   = led_out;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        led_d = 1'b0;
        if (pat_valid && pat_ready) begin
          pat_d   = pat_data;
          rep_d   = pat_reps;
          idx_d   = '0;
          state_d = ARM;
        end
      end
      ARM: begin
        if (stop) begin
          led_d   = 1'b0;
          state_d = IDLE;
        end else if (tick) begin
          led_d   = pat_q[0];
          idx_d   = IW'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          led_d   = 1'b0;
          state_d = IDLE;
        end else if (tick) begin
          if (idx_q != '0) begin
            led_d = pat_q[idx_q];
            // explicit wrap keeps non-power-of-2 pattern lengths legal
            idx_d = (idx_q == IW'(PBITS - 1)) ? '0 : idx_q + IW'(1);
          end else if (rep_q != '0) begin
            led_d = pat_q[0];
            idx_d = IW'(1);
            rep_d = rep_q - RBITS'(1);
          end else begin
            led_d   = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pat_ready = (state_q == IDLE) && !rst;
    busy      = (state_q != IDLE);
  end

endmodule
